// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port DEPTH x DATA_W RAM; read returns the pre-write contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with valid/ready request/response channels and fixed access latency.
// Optional build macro DMEM_BOUNDS_CHECK_EN: flag, drop or zero accesses with req_addr >= DEPTH.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic              busy_r;

    logic              we_p0;
    logic [AW-1:0]     idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              oor_p0;

    logic              req_oor;
    logic              accept;
    logic              enter_resp;
    logic              ram_we;
    logic [AW-1:0]     ram_idx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oor = (bus.req_addr >> AW) != '0;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:AW];
    assign req_oor        = 1'b0;
`endif

    assign accept = req_ready_r && bus.req_valid;

    // With LATENCY==1 the RAM is accessed on the acceptance edge, so it sees the live request.
    assign enter_resp = (state == IDLE && accept && LATENCY == 1) ||
                        (state == WAIT && cnt == CNT_W'(1));
    assign ram_we     = (state == IDLE) ? (bus.req_we && !req_oor) : (we_p0 && !oor_p0);
    assign ram_idx    = (state == IDLE) ? bus.req_addr[AW-1:0] : idx_p0;
    assign ram_wdata  = (state == IDLE) ? bus.req_wdata : wdata_p0;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Stage p0: capture the accepted request
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.req_we;
            idx_p0   <= bus.req_addr[AW-1:0];
            wdata_p0 <= bus.req_wdata;
            oor_p0   <= req_oor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt         <= CNT_W'(LATENCY - 1);
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= req_oor;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= oor_p0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Read data is only visible while a read response is being presented.
    assign bus.rsp_rdata = (rsp_valid_r && !we_p0 && !oor_p0) ? ram_rdata : '0;
    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic oor_of(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return a >= 32'd256;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: computes the expected response and updates the model memory.
    function automatic void push_expect(input bit lat1, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic o;
        int   idx;
        o     = oor_of(addr);
        idx   = int'(addr[7:0]);
        e.err = o;
        if (we) begin
            e.rdata = 32'h0;
            if (!o) begin
                if (lat1) mem1[idx] = wdata;
                else      mem0[idx] = wdata;
            end
        end else begin
            e.rdata = o ? 32'h0 : (lat1 ? mem1[idx] : mem0[idx]);
        end
        if (lat1) sb1.push_back(e);
        else      sb0.push_back(e);
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with req_valid dropped.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            failures++;
            $display("FAIL send_accept addr=%h req_ready=%b required 1", addr, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        push_expect(1'b0, we, addr, wdata);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, samples it, then completes the handshake.
    task automatic wait_rsp(output logic to, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        to = !bus.rsp_valid;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
            bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b valid=%b rdata=%h err=%b busy=%b required 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy);
        end
        checks++;
        if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs_lat1 ready=%b valid=%b busy=%b required 1 0 0",
                     bus1.req_ready, bus1.rsp_valid, bus1.busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic to, er;
        logic [31:0] rd;
        exp_t e;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready_idle req_ready=%b required 1", bus.req_ready);
        end
        send(1'b1, 32'd5, 32'hDEADBEEF);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_after_accept ready=%b busy=%b valid=%b required 0 1 0",
                     bus.req_ready, bus.busy, bus.rsp_valid);
        end
        @(negedge clk);
        e = sb0.pop_front();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            failures++;
            $display("FAIL wr_response valid=%b rdata=%h err=%b required 1 %h %b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_return_idle valid=%b ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
        end
        send(1'b0, 32'd5, 32'h0);
        wait_rsp(to, rd, er);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL rd_addr5 timeout=%b rdata=%h err=%b required 0 %h %b", to, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_backpressure();
        int n;
        exp_t e;
        send(1'b0, 32'd5, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb0.pop_front();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h ready=%b required 1 %h 0",
                         k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, e.rdata);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL bp_release valid=%b ready=%b busy=%b rdata=%h required 0 1 0 0",
                     bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_rdata);
        end
    endtask

    task automatic test_latency1_b2b();
        int   i;
        int   last;
        logic adv;
        exp_t e;
        i    = 0;
        last = -1;
        adv  = 1'b0;
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'd0;
        bus1.req_wdata = 32'd1;
        for (int c = 0; c < 60; c++) begin
            if (adv) begin
                adv = 1'b0;
                if (i < 8) begin
                    bus1.req_we    = (i < 4);
                    bus1.req_addr  = 32'(i % 4);
                    bus1.req_wdata = 32'(i % 4 + 1);
                end else begin
                    bus1.req_valid = 1'b0;
                end
            end
            if (bus1.rsp_valid) begin
                checks++;
                if (sb1.size() == 0) begin
                    failures++;
                    $display("FAIL l1_spurious_rsp rdata=%h required no response", bus1.rsp_rdata);
                end else begin
                    e = sb1.pop_front();
                    if (bus1.rsp_rdata !== e.rdata || bus1.rsp_err !== e.err) begin
                        failures++;
                        $display("FAIL l1_response rdata=%h err=%b required %h %b",
                                 bus1.rsp_rdata, bus1.rsp_err, e.rdata, e.err);
                    end
                end
            end
            if (bus1.req_valid && bus1.req_ready) begin
                push_expect(1'b1, bus1.req_we, bus1.req_addr, bus1.req_wdata);
                if (last >= 0) begin
                    checks++;
                    if (c - last != 2) begin
                        failures++;
                        $display("FAIL l1_spacing gap=%0d required 2", c - last);
                    end
                end
                last = c;
                i++;
                adv = 1'b1;
            end
            if (i >= 8 && !adv && sb1.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (i != 8 || sb1.size() != 0) begin
            failures++;
            $display("FAIL l1_complete accepted=%0d pending=%0d required 8 0", i, sb1.size());
        end
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_bounds();
        logic to, er;
        logic [31:0] rd;
        exp_t e;
        logic [31:0] addrs [4];
        logic        wes   [4];
        logic [31:0] wds   [4];
        addrs = '{32'd44, 32'd300, 32'd44, 32'd300};
        wes   = '{1'b1, 1'b1, 1'b0, 1'b0};
        wds   = '{32'h44444444, 32'h12345678, 32'h0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            send(wes[k], addrs[k], wds[k]);
            wait_rsp(to, rd, er);
            e = sb0.pop_front();
            checks++;
            if (to || rd !== e.rdata || er !== e.err) begin
                failures++;
                $display("FAIL bounds step=%0d addr=%0d timeout=%b rdata=%h err=%b required 0 %h %b",
                         k, addrs[k], to, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic to, er;
        logic [31:0] rd;
        logic [31:0] saved;
        exp_t e;
        send(1'b1, 32'd9, 32'h00000099);
        wait_rsp(to, rd, er);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL rst_prewrite timeout=%b rdata=%h err=%b required 0 %h %b", to, rd, er, e.rdata, e.err);
        end
        saved = mem0[9];
        send(1'b1, 32'd9, 32'h0000CAFE);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_wait busy=%b required 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_async ready=%b valid=%b busy=%b err=%b rdata=%h required 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err, bus.rsp_rdata);
        end
        mem0[9] = saved;
        void'(sb0.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 32'd9, 32'h0);
        wait_rsp(to, rd, er);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL rst_dropped_write timeout=%b rdata=%h err=%b required 0 %h %b",
                     to, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_ignore_busy();
        logic to, er;
        logic [31:0] rd;
        exp_t e;
        send(1'b1, 32'd7, 32'h00000077);
        wait_rsp(to, rd, er);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL ign_prewrite timeout=%b rdata=%h err=%b required 0 %h %b", to, rd, er, e.rdata, e.err);
        end
        send(1'b0, 32'd5, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd7;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL ign_busy cycle=%0d ready=%b busy=%b required 0 1", k, bus.req_ready, bus.busy);
            end
            if (k < 2) @(negedge clk);
        end
        e = sb0.pop_front();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL ign_first_rsp valid=%b rdata=%h required 1 %h", bus.rsp_valid, bus.rsp_rdata, e.rdata);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ign_reidle ready=%b busy=%b valid=%b required 1 0 0",
                     bus.req_ready, bus.busy, bus.rsp_valid);
        end
        push_expect(1'b0, 1'b0, 32'd7, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ign_accept busy=%b required 1", bus.busy);
        end
        wait_rsp(to, rd, er);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("FAIL ign_second_rsp timeout=%b rdata=%h err=%b required 0 %h %b",
                     to, rd, er, e.rdata, e.err);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 32'h0;
        bus1.req_wdata = 32'h0;
        bus1.rsp_ready = 1'b0;

        test_reset();
        test_write_read();
        test_backpressure();
        test_latency1_b2b();
        test_bounds();
        test_reset_wait();
        test_ignore_busy();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
